scan_chain_ctrl: RTL and testbench

SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

---
 rtl/scan_chain_ctrl.sv | 137 +++++++++++++
 tb/tb_scan_chain_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/scan_chain_ctrl.sv
// Scan-chain transaction controller: shifts NTX_BITS bits LSB first using a
// non-overlapping two-phase clock (phi / phi_bar) and captures the chain's serial return.
module scan_chain_ctrl #(
   parameter int NTX_BITS      = 78,
   parameter int TX_BITS_WIDTH = 128,
   parameter int BIT_CNT_WIDTH = 7,
   parameter int PHASE_CYCLES  = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     srst,
   input  logic                     start,
   input  logic [TX_BITS_WIDTH-1:0] data_in,
   input  logic                     scan_data_out,
   output logic                     busy,
   output logic                     done,
   output logic                     scan_id,
   output logic                     scan_phi,
   output logic                     scan_phi_bar,
   output logic                     scan_data_in,
   output logic                     scan_load_chip,
   output logic [TX_BITS_WIDTH-1:0] rd_data,
   output logic [BIT_CNT_WIDTH-1:0] nbits_cnt
);

   localparam int PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_PHI, S_GAP1, S_PHIB, S_GAP2, S_LOAD, S_DONE
   } state_t;

   state_t                   state, state_nxt;
   logic [PW-1:0]            phase_cnt, phase_nxt;
   logic [BIT_CNT_WIDTH-1:0] bit_idx, bit_nxt;
   logic [TX_BITS_WIDTH-1:0] sreg, sreg_nxt, alt_pat;
   logic                     accept, phase_last, bit_last, capture, shifting_nxt;

   // Fallback pattern 0xAAAA_AAAA_AAAA_AAAA used when the low nibble of data_in is zero.
   always_comb begin
      alt_pat = '0;
      for (int i = 0; i < TX_BITS_WIDTH; i++)
         alt_pat[i] = (i < 64) && (i % 2 == 1);
   end

   assign accept     = (state == S_IDLE) && start && !srst;
   assign phase_last = (phase_cnt == PW'(PHASE_CYCLES - 1));
   assign bit_last   = (bit_idx == BIT_CNT_WIDTH'(NTX_BITS - 1));
   assign capture    = (state == S_PHIB) && phase_last && !srst;
   assign nbits_cnt  = bit_idx;

   always_comb begin
      state_nxt = state;
      phase_nxt = phase_cnt;
      bit_nxt   = bit_idx;
      sreg_nxt  = sreg;
      if (srst) begin
         state_nxt = S_IDLE;
         phase_nxt = '0;
         bit_nxt   = '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               state_nxt = S_PHI;
               phase_nxt = '0;
               bit_nxt   = '0;
               sreg_nxt  = (data_in[3:0] == 4'd0) ? alt_pat : data_in;
            end
            S_PHI, S_GAP1, S_PHIB, S_GAP2, S_LOAD: begin
               if (!phase_last) begin
                  phase_nxt = phase_cnt + PW'(1);
               end else begin
                  phase_nxt = '0;
                  case (state)
                     S_PHI:  state_nxt = S_GAP1;
                     S_GAP1: state_nxt = S_PHIB;
                     S_PHIB: state_nxt = S_GAP2;
                     S_GAP2: if (bit_last) begin
                        state_nxt = S_LOAD;
                     end else begin
                        state_nxt = S_PHI;
                        bit_nxt   = bit_idx + BIT_CNT_WIDTH'(1);
                     end
                     default: state_nxt = S_DONE;
                  endcase
               end
            end
            S_DONE: begin
               state_nxt = S_IDLE;
               bit_nxt   = '0;
            end
            default: begin
               state_nxt = S_IDLE;
               phase_nxt = '0;
               bit_nxt   = '0;
            end
         endcase
      end
   end

   assign shifting_nxt = (state_nxt == S_PHI) || (state_nxt == S_GAP1) ||
                         (state_nxt == S_PHIB) || (state_nxt == S_GAP2);

   // Outputs are registered from the next state so they line up exactly with the state slots.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         phase_cnt      <= '0;
         bit_idx        <= '0;
         sreg           <= '0;
         rd_data        <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         scan_id        <= 1'b0;
         scan_phi       <= 1'b0;
         scan_phi_bar   <= 1'b0;
         scan_data_in   <= 1'b0;
         scan_load_chip <= 1'b0;
      end else begin
         state     <= state_nxt;
         phase_cnt <= phase_nxt;
         bit_idx   <= bit_nxt;
         sreg      <= sreg_nxt;
         if (accept)
            rd_data <= '0;
         else if (capture)
            rd_data[bit_idx] <= scan_data_out;
         busy           <= shifting_nxt || (state_nxt == S_LOAD);
         scan_id        <= shifting_nxt || (state_nxt == S_LOAD);
         done           <= (state_nxt == S_DONE);
         scan_phi       <= (state_nxt == S_PHI);
         scan_phi_bar   <= (state_nxt == S_PHIB);
         scan_load_chip <= (state_nxt == S_LOAD);
         scan_data_in   <= shifting_nxt ? sreg_nxt[bit_nxt] : 1'b0;
      end
   end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl: per-cycle output traces compared against hand-derived timelines.
module tb_scan_chain_ctrl;

   logic         clk = 1'b0;
   logic         reset_n, srst, start, sel;
   logic [127:0] data_in;
   logic [6:0]   ctl_a, ctl_b, ctl_m;  // {busy, done, id, phi, phib, sdi, load}
   logic [127:0] rd_a, rd_b, rd_m;
   logic [6:0]   nb_a, nb_b, nb_m;
   logic [127:0] tr_phi, tr_phib, tr_sdi, tr_load, tr_done, tr_busy, tr_id, tr_ovl;
   logic [6:0]   nb13;
   int           checks = 0;
   int           failures = 0;

   always #5 clk = ~clk;

   scan_chain_ctrl #(.NTX_BITS(8), .TX_BITS_WIDTH(128), .BIT_CNT_WIDTH(7), .PHASE_CYCLES(1)) u_a (
      .clk(clk), .reset_n(reset_n), .srst(srst), .start(start), .data_in(data_in),
      .scan_data_out(ctl_a[1]), .busy(ctl_a[6]), .done(ctl_a[5]), .scan_id(ctl_a[4]),
      .scan_phi(ctl_a[3]), .scan_phi_bar(ctl_a[2]), .scan_data_in(ctl_a[1]),
      .scan_load_chip(ctl_a[0]), .rd_data(rd_a), .nbits_cnt(nb_a));

   scan_chain_ctrl #(.NTX_BITS(8), .TX_BITS_WIDTH(128), .BIT_CNT_WIDTH(7), .PHASE_CYCLES(3)) u_b (
      .clk(clk), .reset_n(reset_n), .srst(srst), .start(start), .data_in(data_in),
      .scan_data_out(ctl_b[1]), .busy(ctl_b[6]), .done(ctl_b[5]), .scan_id(ctl_b[4]),
      .scan_phi(ctl_b[3]), .scan_phi_bar(ctl_b[2]), .scan_data_in(ctl_b[1]),
      .scan_load_chip(ctl_b[0]), .rd_data(rd_b), .nbits_cnt(nb_b));

   assign ctl_m = sel ? ctl_b : ctl_a;
   assign rd_m  = sel ? rd_b  : rd_a;
   assign nb_m  = sel ? nb_b  : nb_a;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] span(input int from, input int len);
      logic [127:0] v = '0;
      for (int j = 0; j < len; j++) v[from+j] = 1'b1;
      return v;
   endfunction

   // Cycles in which a given slot (0=PHI .. 3=GAP2) is active across the 8 bits.
   function automatic logic [127:0] slot_tr(input int pc, input int slot);
      logic [127:0] v = '0;
      for (int k = 0; k < 8; k++) v |= span(1 + (4*k + slot)*pc, pc);
      return v;
   endfunction

   function automatic logic [127:0] sdi_tr(input int pc, input logic [7:0] pat);
      logic [127:0] v = '0;
      for (int k = 0; k < 8; k++) if (pat[k]) v |= span(1 + 4*k*pc, 4*pc);
      return v;
   endfunction

   // Start in cycle 0, then record cycles 1..120 sampled on the falling edge.
   task automatic run(input logic [127:0] din, input int srst_at, input int start2_at, input int rst_at);
      @(posedge clk); #1;
      data_in = din;
      start   = 1'b1;
      {tr_phi, tr_phib, tr_sdi, tr_load, tr_done, tr_busy, tr_id, tr_ovl} = '0;
      nb13 = '0;
      for (int c = 1; c <= 120; c++) begin
         @(posedge clk); #1;
         start = (c == start2_at);
         srst  = (c == srst_at);
         if (c == rst_at + 2) reset_n = 1'b1;
         @(negedge clk);
         tr_busy[c] = ctl_m[6];
         tr_done[c] = ctl_m[5];
         tr_id[c]   = ctl_m[4];
         tr_phi[c]  = ctl_m[3];
         tr_phib[c] = ctl_m[2];
         tr_sdi[c]  = ctl_m[1];
         tr_load[c] = ctl_m[0];
         tr_ovl[c]  = ctl_m[3] & ctl_m[2];
         if (c == 13) nb13 = nb_m;
         if (c == rst_at) begin
            chk("phib_before_rst", {127'd0, ctl_m[2]}, 128'd1);
            #2 reset_n = 1'b0;
            #1;
            chk("async_rst_ctl", {121'd0, ctl_m}, 128'd0);
            chk("async_rst_rd", rd_m, 128'd0);
            chk("async_rst_nb", {121'd0, nb_m}, 128'd0);
         end
      end
      srst = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; srst = 1'b0; start = 1'b0; sel = 1'b0; data_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctl", {121'd0, ctl_a}, 128'd0);
      chk("rst_rd", rd_a, 128'd0);
      reset_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("no_autolaunch", {114'd0, ctl_a, nb_a}, 128'd0);

      // 0xA5, one cycle per phase, loopback readback
      run(128'hA5, -1, -1, -1);
      chk("a5_phi",  tr_phi,  slot_tr(1, 0));
      chk("a5_phib", tr_phib, slot_tr(1, 2));
      chk("a5_sdi",  tr_sdi,  sdi_tr(1, 8'hA5));
      chk("a5_load", tr_load, span(33, 1));
      chk("a5_done", tr_done, span(34, 1));
      chk("a5_busy", tr_busy, span(1, 33));
      chk("a5_id",   tr_id,   span(1, 33));
      chk("a5_ovl",  tr_ovl,  128'd0);
      chk("a5_nb13", {121'd0, nb13}, 128'd3);
      chk("a5_rd",   rd_m,    128'hA5);

      // Low nibble zero selects the alternating fallback pattern
      run(128'h50, -1, -1, -1);
      chk("alt_sdi", tr_sdi, sdi_tr(1, 8'hAA));
      chk("alt_rd",  rd_m,   128'hAA);

      // Three cycles per phase
      sel = 1'b1;
      run(128'hA5, -1, -1, -1);
      chk("p3_phi",  tr_phi,  slot_tr(3, 0));
      chk("p3_load", tr_load, span(97, 3));
      chk("p3_done", tr_done, span(100, 1));
      chk("p3_busy", tr_busy, span(1, 99));
      chk("p3_rd",   rd_m,    128'hA5);
      sel = 1'b0;

      // Abort in bit 3 with a stray second start while busy
      run(128'hA5, 13, 5, -1);
      chk("srst_busy", tr_busy, span(1, 13));
      chk("srst_done", tr_done, 128'd0);
      chk("srst_phi",  tr_phi,  span(1, 1) | span(5, 1) | span(9, 1) | span(13, 1));
      chk("srst_rd",   rd_m,    128'h05);
      chk("srst_idle", {121'd0, ctl_m}, 128'd0);

      // Asynchronous reset during PHIB of bit 5, then a clean transaction
      run(128'hA5, -1, -1, 23);
      chk("post_rst_ctl", {121'd0, ctl_m}, 128'd0);
      chk("post_rst_rd",  rd_m, 128'd0);
      run(128'hA5, -1, -1, -1);
      chk("clean_phi",  tr_phi,  slot_tr(1, 0));
      chk("clean_sdi",  tr_sdi,  sdi_tr(1, 8'hA5));
      chk("clean_done", tr_done, span(34, 1));
      chk("clean_rd",   rd_m,    128'hA5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
